// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency / period meter:
//   - period_state_t : period FSM state encoding (IDLE, RUN, TIMEOUT)
//   - CLK_HZ         : board clock rate, default gate window is one second
//   - SYNC_STAGES    : depth of the input synchronizer chain
// -----------------------------------------------------------------------------
package freq_meter_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        TIMEOUT = 2'd2
    } period_state_t;

endpackage

// File: rtl/sig_edge_sync.sv
// -----------------------------------------------------------------------------
// sig_edge_sync
// Brings the asynchronous measured signal into the clk domain and produces a
// one-cycle pulse for each rising edge. This is the only place in the design
// where clk-domain crossing happens.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   sig_in   in   measured signal, asynchronous to clk
//   sig_edge out  registered one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module sig_edge_sync
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_edge
);

    logic [SYNC_STAGES:0]   w_chain;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;

    assign w_chain[0] = sig_in;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= w_chain[gi];
                end
            end
            assign w_chain[gi+1] = r_sync[gi];
        end
    endgenerate

    // r_prev holds the previous synchronized level; the edge pulse is
    // registered so downstream logic sees a clean single-cycle strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_prev <= w_chain[SYNC_STAGES];
            r_edge <= w_chain[SYNC_STAGES] & ~r_prev;
        end
    end

    assign sig_edge = r_edge;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Measures a slow asynchronous input against clk: the period between
// consecutive rising edges, and the number of rising edges in a fixed gate
// window.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   sig_in       in   measured signal, asynchronous to clk
//   period       out  clk cycles between the last two rising edges
//   period_valid out  one-cycle strobe when period updates
//   freq         out  rising edges in the last complete gate window
//   freq_valid   out  one-cycle strobe when freq updates
//   timeout      out  high while no edge seen for 2^CNT_W-1 cycles
// -----------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = CLK_HZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             timeout
);

    localparam int               GW       = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_END = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic w_edge;

    sig_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .sig_edge (w_edge)
    );

    // ---------------- period FSM ----------------
    period_state_t    r_state, w_state_next;
    logic [CNT_W-1:0] r_pcnt, w_pcnt_next;
    logic [CNT_W-1:0] r_period, w_period_next;
    logic             r_period_valid, w_period_valid_next;
    logic             r_timeout, w_timeout_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_pcnt         <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pcnt         <= w_pcnt_next;
            r_period       <= w_period_next;
            r_period_valid <= w_period_valid_next;
            r_timeout      <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_pcnt_next         = r_pcnt;
        w_period_next       = r_period;
        w_period_valid_next = 1'b0;
        w_timeout_next      = r_timeout;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_pcnt_next  = CNT_ONE;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_edge) begin
                    w_period_next       = r_pcnt;
                    w_period_valid_next = 1'b1;
                    w_pcnt_next         = CNT_ONE;
                end else if (r_pcnt == CNT_MAX) begin
                    w_state_next   = TIMEOUT;
                    w_timeout_next = 1'b1;
                end else begin
                    w_pcnt_next = r_pcnt + CNT_ONE;
                end
            end
            TIMEOUT: begin
                // Interval length is unknown after a timeout, so the next
                // edge restarts timing without reporting a period.
                if (w_edge) begin
                    w_timeout_next = 1'b0;
                    w_pcnt_next    = CNT_ONE;
                    w_state_next   = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- gate window counter ----------------
    logic [GW-1:0]    r_gcnt;
    logic [CNT_W-1:0] r_ecnt;
    logic [CNT_W-1:0] r_freq;
    logic             r_freq_valid;
    logic [CNT_W-1:0] w_ecnt_inc;

    // Saturating edge count including the current cycle's edge, so an edge
    // on the terminal cycle lands in the window that is closing.
    assign w_ecnt_inc = (w_edge && (r_ecnt != CNT_MAX)) ? r_ecnt + CNT_ONE : r_ecnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gcnt       <= '0;
            r_ecnt       <= '0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
        end else if (r_gcnt == GATE_END) begin
            r_gcnt       <= '0;
            r_ecnt       <= '0;
            r_freq       <= w_ecnt_inc;
            r_freq_valid <= 1'b1;
        end else begin
            r_gcnt       <= r_gcnt + GW'(1);
            r_ecnt       <= w_ecnt_inc;
            r_freq_valid <= 1'b0;
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign freq         = r_freq;
    assign freq_valid   = r_freq_valid;
    assign timeout      = r_timeout;

endmodule
